// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter: FSM encoding,
// rotating-priority pick and one-hot encode, sized for up to 8 requesters.
package shared_reg_arbiter_pkg;

    localparam int MAX_REQ   = 8;
    localparam int IDX_MAX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    // First set bit of elig scanning upward from ptr, wrapping at n-1.
    function automatic logic [IDX_MAX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   elig,
        input logic [IDX_MAX_W-1:0] ptr,
        input int                   n
    );
        logic [IDX_MAX_W-1:0] res;
        logic [IDX_MAX_W-1:0] idx;
        logic                 found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = IDX_MAX_W'((int'(ptr) + k) % n);
            if (k < n && !found && elig[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_data_reg.sv
// WIDTH-bit shared data register with synchronous active-high reset and load enable.
module shared_data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter for one shared data register, with locked bursts bounded
// by a hold timer. All outputs are registered.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ-1:0]         Lock,
    input  logic [N_REQ*WIDTH-1:0]   WrData,
    output logic [N_REQ-1:0]         Gnt,
    output logic [WIDTH-1:0]         Q,
    output logic [$clog2(N_REQ)-1:0] Owner,
    output logic                     Busy,
    output logic                     Timeout
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   elig;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   sel;
    logic               load;
    logic [WIDTH-1:0]   wr_sel;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        owner_d   = owner_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        load      = 1'b0;
        sel       = owner_q;
        // The requester currently seeing Gnt sits out this edge.
        elig      = Req & ~gnt_q;
        pick      = IDX_W'(rr_pick(MAX_REQ'(elig), IDX_MAX_W'(ptr_q), N_REQ));

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    load    = 1'b1;
                    sel     = pick;
                    gnt_d   = N_REQ'(onehot(IDX_MAX_W'(pick)));
                    owner_d = pick;
                    ptr_d   = pick + IDX_W'(1);
                    if (Lock[pick]) begin
                        state_d = OWNED;
                        hold_d  = HOLD_W'(1);
                        busy_d  = 1'b1;
                    end
                end
            end
            OWNED: begin
                if (!Lock[owner_q]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end else begin
                    if (hold_q == HOLD_W'(MAX_HOLD)) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        timeout_d = 1'b1;
                        hold_d    = '0;
                        ptr_d     = owner_q + IDX_W'(1);
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                    // A pending owner write is still taken on the forced-release edge.
                    if (elig[owner_q]) begin
                        load  = 1'b1;
                        gnt_d = N_REQ'(onehot(IDX_MAX_W'(owner_q)));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign wr_sel = WrData[int'(sel)*WIDTH +: WIDTH];

    shared_data_reg #(.WIDTH(WIDTH)) u_data_reg (
        .clk  (Clock),
        .rst  (Reset),
        .load (load),
        .d    (wr_sel),
        .q    (Q)
    );

    assign Gnt     = gnt_q;
    assign Owner   = owner_q;
    assign Busy    = busy_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=8).
module tb_shared_reg_arbiter;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Req;
    logic [3:0]  Lock;
    logic [31:0] WrData;
    logic [3:0]  Gnt;
    logic [7:0]  Q;
    logic [1:0]  Owner;
    logic        Busy;
    logic        Timeout;

    int n_pass  = 0;
    int n_total = 0;

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(8)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .Lock    (Lock),
        .WrData  (WrData),
        .Gnt     (Gnt),
        .Q       (Q),
        .Owner   (Owner),
        .Busy    (Busy),
        .Timeout (Timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [7:0] q,
                           input logic [1:0] o, input logic b, input logic t);
        chk({tag, ".gnt"},     32'(Gnt),     32'(g));
        chk({tag, ".q"},       32'(Q),       32'(q));
        chk({tag, ".owner"},   32'(Owner),   32'(o));
        chk({tag, ".busy"},    32'(Busy),    32'(b));
        chk({tag, ".timeout"}, 32'(Timeout), 32'(t));
    endtask

    initial begin
        Reset  = 1'b1;
        Req    = 4'b1111;
        Lock   = 4'b0000;
        WrData = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset held two edges with all requesters asking
        step(); chk_out("rst0", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        step(); chk_out("rst1", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Round robin, no locks
        step(); chk_out("rr0", 4'b0001, 8'hA0, 2'd0, 1'b0, 1'b0);
        step(); chk_out("rr1", 4'b0010, 8'hB1, 2'd1, 1'b0, 1'b0);
        step(); chk_out("rr2", 4'b0100, 8'hC2, 2'd2, 1'b0, 1'b0);
        step(); chk_out("rr3", 4'b1000, 8'hD3, 2'd3, 1'b0, 1'b0);
        step(); chk_out("rr4", 4'b0001, 8'hA0, 2'd0, 1'b0, 1'b0);
        Req = 4'b0000;
        step(); chk_out("idle0", 4'b0000, 8'hA0, 2'd0, 1'b0, 1'b0);

        // Locked burst by requester 2 while requester 0 waits (ptr=1)
        Req = 4'b0101; Lock = 4'b0100;
        step(); chk_out("lk0", 4'b0100, 8'hC2, 2'd2, 1'b1, 1'b0);
        Req = 4'b0001; WrData[23:16] = 8'hE2;
        step(); chk_out("lk1", 4'b0000, 8'hC2, 2'd2, 1'b1, 1'b0);
        Req = 4'b0101;
        step(); chk_out("lk2", 4'b0100, 8'hE2, 2'd2, 1'b1, 1'b0);
        Req = 4'b0001;
        step(); chk_out("lk3", 4'b0000, 8'hE2, 2'd2, 1'b1, 1'b0);
        Lock = 4'b0000;
        step(); chk_out("lkrel", 4'b0000, 8'hE2, 2'd2, 1'b0, 1'b0);
        step(); chk_out("lkafter", 4'b0001, 8'hA0, 2'd0, 1'b0, 1'b0);
        Req = 4'b0000;
        step(); chk_out("idle1", 4'b0000, 8'hA0, 2'd0, 1'b0, 1'b0);

        // Hold-timer timeout on requester 1 (ptr=1)
        Req = 4'b0010; Lock = 4'b0010;
        step(); chk_out("to0", 4'b0010, 8'hB1, 2'd1, 1'b1, 1'b0);
        Req = 4'b1011;
        step(); chk_out("to1", 4'b0000, 8'hB1, 2'd1, 1'b1, 1'b0);
        WrData[15:8] = 8'h11;
        step(); chk_out("to2", 4'b0010, 8'h11, 2'd1, 1'b1, 1'b0);
        step(); chk_out("to3", 4'b0000, 8'h11, 2'd1, 1'b1, 1'b0);
        step(); chk_out("to4", 4'b0010, 8'h11, 2'd1, 1'b1, 1'b0);
        step(); chk_out("to5", 4'b0000, 8'h11, 2'd1, 1'b1, 1'b0);
        step(); chk_out("to6", 4'b0010, 8'h11, 2'd1, 1'b1, 1'b0);
        step(); chk_out("to7", 4'b0000, 8'h11, 2'd1, 1'b1, 1'b0);
        step(); chk_out("to8", 4'b0010, 8'h11, 2'd1, 1'b0, 1'b1);
        step(); chk_out("toafter", 4'b1000, 8'hD3, 2'd3, 1'b0, 1'b0);
        Req = 4'b0000; Lock = 4'b0000;
        step(); chk_out("idle2", 4'b0000, 8'hD3, 2'd3, 1'b0, 1'b0);

        // Lock drop on the edge where hold reaches MAX_HOLD (ptr=0)
        Req = 4'b0010; Lock = 4'b0010;
        step(); chk_out("sim0", 4'b0010, 8'h11, 2'd1, 1'b1, 1'b0);
        Req = 4'b0000;
        for (int i = 1; i < 8; i++) step();
        chk_out("sim7", 4'b0000, 8'h11, 2'd1, 1'b1, 1'b0);
        Lock = 4'b0000;
        step(); chk_out("simrel", 4'b0000, 8'h11, 2'd1, 1'b0, 1'b0);
        Req = 4'b1111;
        step(); chk_out("simafter", 4'b0100, 8'hE2, 2'd2, 1'b0, 1'b0);

        // Reset in the middle of a locked burst (ptr=3)
        Req = 4'b1000; Lock = 4'b1000;
        step(); chk_out("rb0", 4'b1000, 8'hD3, 2'd3, 1'b1, 1'b0);
        Req = 4'b0000;
        step(); step();
        chk_out("rb2", 4'b0000, 8'hD3, 2'd3, 1'b1, 1'b0);
        Reset = 1'b1; Req = 4'b1111; Lock = 4'b1111;
        step(); chk_out("rbrst", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        Reset = 1'b0; Lock = 4'b0000;
        step(); chk_out("rbafter", 4'b0001, 8'hA0, 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
